packet_sink: RTL and testbench
==============================

PACKET_SINK -- requirements
Module: packet_sink

Interface
REQ-001 Parameter ID, default 0, instance number used in debug print prefix ("Packet Sink", ID).
REQ-002 Parameter FLITS, default 8, flits per packet, range 1..255.
REQ-003 Parameter SIZE, default 8, flit width in bits; bit SIZE-1 is the head marker.
REQ-004 Parameter PACKETS, default 2, packet count that asserts done, range 1..255.
REQ-005 Parameter ACK_DELAY, default 0, cycles from flit acceptance to ack toggle, range 0..15.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 req  input  1  two-phase request; each toggle offers one flit.
REQ-009 data  input  SIZE  flit payload; stable while a request is outstanding.
REQ-010 ack  output  1  two-phase acknowledge; each toggle completes one handshake.
REQ-011 pkt_valid  output  1  one-cycle pulse: pkt_data holds a newly completed packet.
REQ-012 pkt_data  output  FLITS*SIZE  last completed packet; flit 0 in bits [SIZE-1:0], flit k in bits [(k+1)*SIZE-1:k*SIZE].
REQ-013 pkt_count  output  8  completed packets, saturating at 255.
REQ-014 err_count  output  8  framing errors, saturating at 255.
REQ-015 done  output  1  sticky; set when pkt_count reaches PACKETS.

Function
REQ-016 Internal register req_seen SHALL track the req phase last accepted; pending = req XOR req_seen.
REQ-017 FSM states SHALL be IDLE and WAIT only.
REQ-018 IDLE with pending: accept flit (latch data, toggle req_seen); ACK_DELAY=0 -> toggle ack on that same edge and stay IDLE; otherwise load delay counter with ACK_DELAY and go to WAIT.
REQ-019 WAIT: decrement counter each edge; on the edge where counter is 1, toggle ack and return to IDLE; ack thus toggles exactly ACK_DELAY edges after acceptance.
REQ-020 A req toggle arriving in WAIT SHALL remain pending and be accepted on the first IDLE edge; flits are never dropped or double-accepted.
REQ-021 Flit index idx (0..FLITS-1) SHALL steer assembly on each accepted flit:
  - head=1, idx=0: store as flit 0, idx<=1.
  - head=0, idx>0: store at idx, idx<=idx+1.
  - head=1, idx>0: truncated packet; discard partial, err_count+1, store as flit 0, idx<=1.
  - head=0, idx=0: orphan body; discard flit, err_count+1, idx stays 0.
REQ-022 When a stored flit fills index FLITS-1 (or the head flit when FLITS=1): on that edge pkt_data<=assembled packet, pkt_valid<=1, pkt_count+1, idx<=0.
REQ-023 pkt_valid SHALL be 1 for exactly one cycle per completed packet, else 0.
REQ-024 done SHALL rise on the edge pkt_count becomes PACKETS and hold until reset.
REQ-025 After done, handshakes, assembly and counting SHALL continue unchanged.
REQ-026 Framing errors SHALL never stall the handshake; every accepted flit is acked.
REQ-027 On completion and on each error, SHALL print prefix plus "received packet <0x..>" or "framing error" (simulation only).

Reset
REQ-028 While reset=1 at a posedge: ack=0, req_seen=0, pkt_valid=0, pkt_data=0, pkt_count=0, err_count=0, done=0, idx=0, state=IDLE, delay counter=0.
REQ-029 Reset mid-packet or in WAIT SHALL discard the partial packet and any ungiven ack.
REQ-030 If req=1 on the first edge after reset release, this SHALL count as pending and be accepted.

Verification
REQ-031 FLITS=8, SIZE=8, ACK_DELAY=0; send 0x81,0x01..0x07 -> 8 ack toggles, each on its acceptance edge; pkt_valid once; pkt_data=0x0706050403020181; pkt_count=1.
REQ-032 PACKETS=2; two clean packets -> done=1 on the second completion edge; a third packet -> pkt_count=3, done still 1.
REQ-033 Send 0x81,0x11,0x22 then 0x85 + 7 body flits -> err_count=1; exactly one packet completes, with flit 0=0x85.
REQ-034 Send body 0x33 at idx=0 -> ack toggles, err_count=1, no pkt_valid; next clean packet completes normally.
REQ-035 ACK_DELAY=3 -> ack toggles 3 edges after each acceptance; req toggled early during WAIT -> accepted on first IDLE edge, no flit lost.
REQ-036 Reset asserted after 4 flits -> all outputs 0; fresh clean packet afterwards completes with pkt_count=1.

Source files
------------

// File: rtl/packet_sink.sv
// Two-phase req/ack flit sink that assembles head-marked flits into packets,
// counting completed packets and framing errors, with an optional ack delay.
module packet_sink #(
  parameter int unsigned ID        = 0,
  parameter int unsigned FLITS     = 8,
  parameter int unsigned SIZE      = 8,
  parameter int unsigned PACKETS   = 2,
  parameter int unsigned ACK_DELAY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [SIZE-1:0]       data,
  output logic                  ack,
  output logic                  pkt_valid,
  output logic [FLITS*SIZE-1:0] pkt_data,
  output logic [7:0]            pkt_count,
  output logic [7:0]            err_count,
  output logic                  done
);

  localparam logic [7:0] LastIdx    = 8'(FLITS - 1);
  localparam logic [7:0] PacketsCnt = 8'(PACKETS);
  localparam logic [3:0] AckDelay   = 4'(ACK_DELAY);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state;
  logic                  req_seen;
  logic [3:0]            delay_cnt;
  logic [7:0]            idx;
  logic [FLITS*SIZE-1:0] asm_q;

  logic                  pending;
  logic                  head;
  logic                  store;
  logic                  framing_err;
  logic                  complete;
  logic [7:0]            pos;
  logic [7:0]            pkt_count_inc;
  logic [FLITS*SIZE-1:0] pkt_next;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  always_comb begin
    pending       = req ^ req_seen;
    head          = data[SIZE-1];
    store         = head || (idx != 8'd0);
    framing_err   = head ? (idx != 8'd0) : (idx == 8'd0);
    pos           = head ? 8'd0 : idx;
    complete      = store && (pos == LastIdx);
    pkt_count_inc = sat_inc(pkt_count);
    // A head flit always starts a fresh packet, dropping any partial one.
    pkt_next      = head ? '0 : asm_q;
    for (int k = 0; k < int'(FLITS); k++) begin
      if (k == int'(pos)) pkt_next[k*SIZE +: SIZE] = data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      req_seen  <= 1'b0;
      delay_cnt <= 4'd0;
      idx       <= 8'd0;
      asm_q     <= '0;
      ack       <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      pkt_count <= 8'd0;
      err_count <= 8'd0;
      done      <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (pending) begin
            req_seen <= req;
            if (ACK_DELAY == 0) begin
              ack <= ~ack;
            end else begin
              delay_cnt <= AckDelay;
              state     <= StWait;
            end
            if (framing_err) err_count <= sat_inc(err_count);
            if (store) begin
              if (complete) begin
                pkt_data  <= pkt_next;
                pkt_valid <= 1'b1;
                pkt_count <= pkt_count_inc;
                idx       <= 8'd0;
                if (pkt_count_inc == PacketsCnt) done <= 1'b1;
              end else begin
                asm_q <= pkt_next;
                idx   <= pos + 8'd1;
              end
            end
          end
        end
        StWait: begin
          // New req toggles stay pending here and are taken once back in idle.
          delay_cnt <= delay_cnt - 4'd1;
          if (delay_cnt == 4'd1) begin
            ack   <= ~ack;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && state == StIdle && pending) begin
      if (framing_err) $display("Packet Sink %0d: framing error", ID);
      if (complete) $display("Packet Sink %0d: received packet 0x%h", ID, pkt_next);
    end
  end
`endif

endmodule

// File: tb/tb_packet_sink.sv
// Directed bench for packet_sink: table-driven flit vectors on a zero-delay
// instance plus hand-written sequences for ack delay and reset corner cases.
module tb_packet_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req3;
  logic [7:0]  data0, data3;
  logic        ack0, ack3, pv0, pv3, done0, done3;
  logic [63:0] pd0, pd3;
  logic [7:0]  pc0, pc3, ec0, ec3;

  int errors = 0;
  int checks = 0;
  logic exp_ack0 = 1'b0;

  always #5 clk = ~clk;

  packet_sink #(.ID(0), .FLITS(8), .SIZE(8), .PACKETS(2), .ACK_DELAY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .data(data0), .ack(ack0), .pkt_valid(pv0),
    .pkt_data(pd0), .pkt_count(pc0), .err_count(ec0), .done(done0)
  );

  packet_sink #(.ID(3), .FLITS(8), .SIZE(8), .PACKETS(2), .ACK_DELAY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .data(data3), .ack(ack3), .pkt_valid(pv3),
    .pkt_data(pd3), .pkt_count(pc3), .err_count(ec3), .done(done3)
  );

  typedef struct {
    logic [7:0]  d;
    logic        valid;
    logic [7:0]  pc;
    logic [7:0]  ec;
    logic        dn;
    logic [63:0] pkt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] d, input logic v, input logic [7:0] pc,
                         input logic [7:0] ec, input logic dn, input logic [63:0] pkt);
    vec_t e;
    e.d = d; e.valid = v; e.pc = pc; e.ec = ec; e.dn = dn; e.pkt = pkt;
    vecs.push_back(e);
  endtask

  // Head flit then bodies base+1..base+7; completion on the last body flit.
  task automatic add_pkt(input logic [7:0] hd, input logic [7:0] base, input logic [7:0] pc,
                         input logic [7:0] ec, input logic dn_before, input logic dn_after,
                         input logic [63:0] pkt);
    add_vec(hd, 1'b0, pc, ec, dn_before, 64'h0);
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) add_vec(base + 8'(k), 1'b1, pc + 8'd1, ec, dn_after, pkt);
      else        add_vec(base + 8'(k), 1'b0, pc, ec, dn_before, 64'h0);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    @(negedge clk);
    data0 = v.d;
    req0  = ~req0;
    exp_ack0 = ~exp_ack0;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d ack", n), 64'(ack0), 64'(exp_ack0));
    chk($sformatf("v%0d pkt_valid", n), 64'(pv0), 64'(v.valid));
    chk($sformatf("v%0d pkt_count", n), 64'(pc0), 64'(v.pc));
    chk($sformatf("v%0d err_count", n), 64'(ec0), 64'(v.ec));
    chk($sformatf("v%0d done", n), 64'(done0), 64'(v.dn));
    if (v.valid) chk($sformatf("v%0d pkt_data", n), pd0, v.pkt);
  endtask

  task automatic send3(input logic [7:0] d, output int cycles, output int pulses);
    @(negedge clk);
    data3 = d;
    req3  = ~req3;
    cycles = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (pv3) pulses++;
      if (ack3 == req3) break;
    end
  endtask

  initial begin
    int cyc, pls, tot;
    reset = 1'b1; req0 = 1'b0; req3 = 1'b0; data0 = 8'h0; data3 = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ack0", 64'(ack0), 64'h0);
    chk("rst pkt_valid", 64'(pv0), 64'h0);
    chk("rst pkt_data", pd0, 64'h0);
    chk("rst pkt_count", 64'(pc0), 64'h0);
    chk("rst err_count", 64'(ec0), 64'h0);
    chk("rst done", 64'(done0), 64'h0);
    chk("rst ack3", 64'(ack3), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Ack delay 3 with a req toggle arriving while the first ack is pending.
    @(negedge clk);
    data3 = 8'h81; req3 = 1'b1;
    @(posedge clk); #1;
    chk("d3 accept edge ack", 64'(ack3), 64'h0);
    @(negedge clk);
    data3 = 8'h01; req3 = 1'b0;
    @(posedge clk); #1; chk("d3 e1 ack", 64'(ack3), 64'h0);
    @(posedge clk); #1; chk("d3 e2 ack", 64'(ack3), 64'h0);
    @(posedge clk); #1; chk("d3 e3 ack", 64'(ack3), 64'h1);
    @(posedge clk); #1; chk("d3 e4 ack", 64'(ack3), 64'h1);
    @(posedge clk); #1; chk("d3 e5 ack", 64'(ack3), 64'h1);
    @(posedge clk); #1; chk("d3 e6 ack", 64'(ack3), 64'h1);
    @(posedge clk); #1; chk("d3 e7 ack", 64'(ack3), 64'h0);
    tot = 0;
    for (int k = 2; k <= 7; k++) begin
      send3(8'(k), cyc, pls);
      chk($sformatf("d3 flit%0d ack latency", k), 64'(cyc), 64'd4);
      tot += pls;
    end
    chk("d3 pkt_valid pulses", 64'(tot), 64'd1);
    chk("d3 pkt_data", pd3, 64'h0706050403020181);
    chk("d3 pkt_count", 64'(pc3), 64'd1);
    chk("d3 err_count", 64'(ec3), 64'd0);

    // Zero-delay table: clean packets, done, truncation and orphan errors.
    add_pkt(8'h81, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0, 64'h0706050403020181);
    add_pkt(8'h82, 8'h10, 8'd1, 8'd0, 1'b0, 1'b1, 64'h1716151413121182);
    add_pkt(8'h83, 8'h20, 8'd2, 8'd0, 1'b1, 1'b1, 64'h2726252423222183);
    add_vec(8'h81, 1'b0, 8'd3, 8'd0, 1'b1, 64'h0);
    add_vec(8'h11, 1'b0, 8'd3, 8'd0, 1'b1, 64'h0);
    add_vec(8'h22, 1'b0, 8'd3, 8'd0, 1'b1, 64'h0);
    add_pkt(8'h85, 8'h30, 8'd3, 8'd1, 1'b1, 1'b1, 64'h3736353433323185);
    add_vec(8'h33, 1'b0, 8'd4, 8'd2, 1'b1, 64'h0);
    add_pkt(8'h84, 8'h40, 8'd4, 8'd2, 1'b1, 1'b1, 64'h4746454443424184);
    add_vec(8'h81, 1'b0, 8'd5, 8'd2, 1'b1, 64'h0);
    add_vec(8'h01, 1'b0, 8'd5, 8'd2, 1'b1, 64'h0);
    add_vec(8'h02, 1'b0, 8'd5, 8'd2, 1'b1, 64'h0);
    add_vec(8'h03, 1'b0, 8'd5, 8'd2, 1'b1, 64'h0);
    for (int n = 0; n < vecs.size(); n++) apply_vec(vecs[n], n);

    // Reset mid-packet; req held high so the first edge after release accepts.
    @(negedge clk);
    reset = 1'b1; req0 = 1'b1; data0 = 8'h81; req3 = 1'b0;
    @(posedge clk); #1;
    chk("mid rst ack", 64'(ack0), 64'h0);
    chk("mid rst pkt_valid", 64'(pv0), 64'h0);
    chk("mid rst pkt_data", pd0, 64'h0);
    chk("mid rst pkt_count", 64'(pc0), 64'h0);
    chk("mid rst err_count", 64'(ec0), 64'h0);
    chk("mid rst done", 64'(done0), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post rst accept ack", 64'(ack0), 64'h1);
    chk("post rst pkt_count", 64'(pc0), 64'h0);
    exp_ack0 = 1'b1;
    vecs.delete();
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) add_vec(8'(k), 1'b1, 8'd1, 8'd0, 1'b0, 64'h0706050403020181);
      else        add_vec(8'(k), 1'b0, 8'd0, 8'd0, 1'b0, 64'h0);
    end
    for (int n = 0; n < vecs.size(); n++) apply_vec(vecs[n], 100 + n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
